ring_seq_checker: RTL and testbench
===================================

Name: ring_seq_checker

Overview:
- Receive-side companion to the team's one-hot ring counter. Samples a WIDTH-bit ring bus every enabled cycle and decodes it to a binary position.
- Locks onto the rotating sequence and checks that each step is a legal single rotation.
- Counts completed laps and flags and counts sequence errors.
- Sits next to any ring-counter-driven sequencer as a decoder and integrity monitor.

Parameters:
WIDTH, 4, ring length in bits (>=2).
CNTW, 8, width of lap and error counters.

Ports:
clk  input  1  system clock, all state updates on rising edge.
clr  input  1  synchronous active-high reset.
ring_in  input  WIDTH  sampled ring bus; bit k set means position k.
en  input  1  sample strobe; ring_in is evaluated only in cycles with en=1.
resync  input  1  drop lock or clear error and return to UNSYNC.
idx  output  $clog2(WIDTH)  binary position of the last accepted sample.
idx_valid  output  1  idx holds a checked position; high only in LOCKED.
locked  output  1  FSM in LOCKED.
err  output  1  FSM in ERROR; sticky.
err_code  output  2  00 none, 01 not one-hot, 10 wrong rotation; holds first error.
lap_cnt  output  CNTW  completed laps; saturates at all-ones.
err_cnt  output  CNTW  error events; saturates at all-ones.

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high. clr has priority over every other input.
- Reset values: state UNSYNC, prev sample 0, idx 0, idx_valid 0, locked 0, err 0, err_code 00, lap_cnt 0, err_cnt 0.
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N, i.e. 1-cycle latency.
- One-hot legal: exactly one bit of ring_in is set. The all-zero and multi-bit patterns are illegal.
- Expected next value: {prev[WIDTH-2:0], prev[WIDTH-1]}. Bit k moves to bit k+1, and bit WIDTH-1 wraps to bit 0.
- State UNSYNC:
  - en=1 with legal one-hot: capture prev=ring_in, set idx=position, go LOCKED.
  - Illegal samples here are ignored; no error is raised.
- State LOCKED:
  - en=1, ring_in == expected: update prev and idx.
  - If the old idx was WIDTH-1 and the new idx is 0, lap_cnt++ (saturating).
  - en=1, ring_in not one-hot: go ERROR, err_code=01, err_cnt++.
  - en=1, ring_in one-hot but != expected (skip, stall, reverse): go ERROR, err_code=10, err_cnt++.
  - en=0: no check, no state change.
- State ERROR:
  - err=1, idx_valid=0, idx and prev hold.
  - Further en samples are ignored; err_cnt does not increment again.
- resync=1, in any state: go UNSYNC next cycle and clear err and err_code. The same-cycle sample is ignored. lap_cnt and err_cnt are preserved.
- The locking sample never counts as a lap, even when it is position 0.
- Reset mid-operation: clr on any edge returns every register to its reset value, regardless of en or resync.
- Counters saturate at 2^CNTW-1 and never wrap.

Decomposition:
- Package ring_pkg holds:
  - state enum {UNSYNC, LOCKED, ERROR};
  - err_code localparams ERR_NONE, ERR_ONEHOT, ERR_ROTATE;
  - a rotate-left helper function parameterised by width.
- Sub-module onehot_enc (combinational, WIDTH parameter) takes the vector and outputs a binary index plus a legal flag. It is instantiated once, on ring_in.

Test Plan:
- Lock and rotate: clr, then en=1 with ring_in 0001, 0010, 0100, 1000, 0001 -> locked=1 after the first edge; idx 0,1,2,3,0; lap_cnt=1; err=0.
- Not one-hot: locked at 0010, then en=1 with 0110 -> err=1, err_code=01, err_cnt=1, idx_valid=0, idx stays 1. A further 0000 sample -> err_cnt stays 1.
- Wrong rotation: locked at 0001, then 0100 -> err_code=10, err_cnt=1. Then resync=1 -> UNSYNC with err=0; 1000 locks with idx=3 and lap_cnt unchanged.
- en gating: locked at 0100, en=0 for 5 cycles with garbage 1111 on ring_in -> no error, idx=2. Then en=1 with 1000 -> idx=3.
- Saturation (CNTW=2): run 5 full laps -> lap_cnt=3. Force 4 error/resync cycles -> err_cnt=3.
- Reset mid-operation: locked at idx=2 with lap_cnt=2, assert clr for one cycle together with en=1 and 1000 -> all outputs at reset values; the next legal sample re-locks.

Source files
------------

// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Shared types and helpers for the ring sequence checker.
//   ring_state_t : checker FSM states (UNSYNC, LOCKED, ERROR)
//   ERR_*        : err_code encodings reported by the checker
//   rotl1        : one-step rotate-left of the low w bits of a vector
// ---------------------------------------------------------------------------
package ring_pkg;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } ring_state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_ROTATE = 2'b10;

    // Widest ring the rotate helper can handle.
    localparam int ROT_MAXW = 64;

    // Rotates the low w bits of v left by one: bit k moves to k+1 and bit
    // w-1 wraps to bit 0. Bits at and above w come back as zero, so a
    // caller can cast the result down to its own width. All indices are
    // constant after loop unrolling, so this maps to plain wiring.
    function automatic logic [ROT_MAXW-1:0] rotl1(input logic [ROT_MAXW-1:0] v,
                                                  input int w);
        logic [ROT_MAXW-1:0] r;
        r = '0;
        for (int j = 0; j < ROT_MAXW; j++) begin
            if (j == w - 1) begin
                r[0] = v[j];
            end
        end
        for (int i = 1; i < ROT_MAXW; i++) begin
            if (i < w) begin
                r[i] = v[i-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// ---------------------------------------------------------------------------
// onehot_enc
// Combinational one-hot to binary encoder with a legality flag.
//   i_vec   : input vector, WIDTH bits
//   o_idx   : binary position of the set bit (meaningful only when o_legal)
//   o_legal : 1 when exactly one bit of i_vec is set
// ---------------------------------------------------------------------------
module onehot_enc
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         i_vec,
    output logic [$clog2(WIDTH)-1:0] o_idx,
    output logic                     o_legal
);

    localparam int IW = $clog2(WIDTH);

    logic w_seen;
    logic w_multi;

    // Scan every bit, remembering whether we have already seen a set bit;
    // a second set bit marks the vector as multi-hot. ORing positions
    // together gives the right index when exactly one bit is set, and the
    // index is don't-care otherwise because o_legal is low.
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
                o_idx  = o_idx | IW'(i);
            end
        end
        o_legal = w_seen & ~w_multi;
    end

endmodule

// File: rtl/ring_seq_checker.sv
// ---------------------------------------------------------------------------
// ring_seq_checker
// Receive-side decoder and integrity monitor for a one-hot ring bus. Locks
// onto the rotating pattern, reports the binary position, counts laps and
// flags the first illegal step (sticky until resync).
//   clk       : clock, all state changes on the rising edge
//   clr       : synchronous active-high reset, highest priority
//   ring_in   : sampled ring bus, bit k set means position k
//   en        : sample strobe; ring_in only evaluated when high
//   resync    : drop lock / clear error, return to UNSYNC
//   idx       : binary position of the last accepted sample
//   idx_valid : idx holds a checked position (LOCKED only)
//   locked    : checker is in LOCKED
//   err       : checker is in ERROR (sticky)
//   err_code  : 00 none, 01 not one-hot, 10 wrong rotation
//   lap_cnt   : completed laps, saturating
//   err_cnt   : error events, saturating
// ---------------------------------------------------------------------------
module ring_seq_checker
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     en,
    input  logic                     resync,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [CNTW-1:0]          lap_cnt,
    output logic [CNTW-1:0]          err_cnt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    ring_state_t      r_state;
    logic [WIDTH-1:0] r_prev;
    logic [IW-1:0]    r_idx;
    logic             r_locked;
    logic             r_err;
    logic [1:0]       r_errCode;
    logic [CNTW-1:0]  r_lapCnt;
    logic [CNTW-1:0]  r_errCnt;

    ring_state_t      w_stateNext;
    logic [WIDTH-1:0] w_prevNext;
    logic [IW-1:0]    w_idxNext;
    logic [1:0]       w_errCodeNext;
    logic [CNTW-1:0]  w_lapCntNext;
    logic [CNTW-1:0]  w_errCntNext;

    logic [IW-1:0]    w_encIdx;
    logic             w_encLegal;
    logic [WIDTH-1:0] w_expected;
    logic [CNTW-1:0]  w_lapInc;
    logic [CNTW-1:0]  w_errInc;

    // Single encoder on the raw bus; its legal flag drives both the lock
    // decision in UNSYNC and the not-one-hot check in LOCKED.
    onehot_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_vec   (ring_in),
        .o_idx   (w_encIdx),
        .o_legal (w_encLegal)
    );

    // The only legal successor of the last accepted sample is its one-step
    // left rotation. The helper works on a wide vector, so we widen the
    // previous sample going in and cast back to ring width coming out.
    assign w_expected = WIDTH'(rotl1(ROT_MAXW'(r_prev), WIDTH));

    // Saturating increments: once a counter hits all-ones it stays there.
    assign w_lapInc = (r_lapCnt == '1) ? r_lapCnt : r_lapCnt + 1'b1;
    assign w_errInc = (r_errCnt == '1) ? r_errCnt : r_errCnt + 1'b1;

    // Next-state and next-register logic. resync wins over any sample in
    // the same cycle. Once locked, a bad sample is classified as not
    // one-hot first; only a clean one-hot that is not the expected rotation
    // counts as a rotation error. The lap is counted on the wrap from the
    // last position back to 0, which can never happen on the locking
    // sample because that one is taken in UNSYNC.
    always_comb begin
        w_stateNext   = r_state;
        w_prevNext    = r_prev;
        w_idxNext     = r_idx;
        w_errCodeNext = r_errCode;
        w_lapCntNext  = r_lapCnt;
        w_errCntNext  = r_errCnt;

        if (resync) begin
            w_stateNext   = UNSYNC;
            w_errCodeNext = ERR_NONE;
        end else if (en) begin
            case (r_state)
                UNSYNC: begin
                    if (w_encLegal) begin
                        w_prevNext  = ring_in;
                        w_idxNext   = w_encIdx;
                        w_stateNext = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!w_encLegal) begin
                        w_stateNext   = ERROR;
                        w_errCodeNext = ERR_ONEHOT;
                        w_errCntNext  = w_errInc;
                    end else if (ring_in != w_expected) begin
                        w_stateNext   = ERROR;
                        w_errCodeNext = ERR_ROTATE;
                        w_errCntNext  = w_errInc;
                    end else begin
                        w_prevNext = ring_in;
                        w_idxNext  = w_encIdx;
                        if (r_idx == LAST_IDX) begin
                            w_lapCntNext = w_lapInc;
                        end
                    end
                end
                ERROR: begin
                    w_stateNext = ERROR;
                end
                default: begin
                    w_stateNext = UNSYNC;
                end
            endcase
        end
    end

    // State register. locked/err are registered from the next state so
    // every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= UNSYNC;
            r_prev    <= '0;
            r_idx     <= '0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= ERR_NONE;
            r_lapCnt  <= '0;
            r_errCnt  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_prev    <= w_prevNext;
            r_idx     <= w_idxNext;
            r_locked  <= (w_stateNext == LOCKED);
            r_err     <= (w_stateNext == ERROR);
            r_errCode <= w_errCodeNext;
            r_lapCnt  <= w_lapCntNext;
            r_errCnt  <= w_errCntNext;
        end
    end

    assign idx       = r_idx;
    assign idx_valid = r_locked;
    assign locked    = r_locked;
    assign err       = r_err;
    assign err_code  = r_errCode;
    assign lap_cnt   = r_lapCnt;
    assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_ring_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_ring_seq_checker
// Self-checking bench for ring_seq_checker. Two instances share inputs: the
// default CNTW=8 one and a CNTW=2 one for counter saturation. A position
// based reference model tracks the expected outputs for random traffic.
// ---------------------------------------------------------------------------
module tb_ring_seq_checker;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       resync;
    logic [3:0] ringIn;

    logic [1:0] idx;
    logic       idxValid;
    logic       locked;
    logic       err;
    logic [1:0] errCode;
    logic [7:0] lapCnt;
    logic [7:0] errCnt;

    logic [1:0] sIdx;
    logic       sIdxValid;
    logic       sLocked;
    logic       sErr;
    logic [1:0] sErrCode;
    logic [1:0] sLapCnt;
    logic [1:0] sErrCnt;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = UNSYNC, 1 = LOCKED, 2 = ERROR; position held as
    // an integer, successor is (pos+1) mod W.
    int mState;
    int mPos;
    int mCode;
    int mLap;
    int mErr;

    ring_seq_checker #(.WIDTH(4), .CNTW(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .ring_in   (ringIn),
        .en        (en),
        .resync    (resync),
        .idx       (idx),
        .idx_valid (idxValid),
        .locked    (locked),
        .err       (err),
        .err_code  (errCode),
        .lap_cnt   (lapCnt),
        .err_cnt   (errCnt)
    );

    ring_seq_checker #(.WIDTH(4), .CNTW(2)) dutSat (
        .clk       (clk),
        .clr       (clr),
        .ring_in   (ringIn),
        .en        (en),
        .resync    (resync),
        .idx       (sIdx),
        .idx_valid (sIdxValid),
        .locked    (sLocked),
        .err       (sErr),
        .err_code  (sErrCode),
        .lap_cnt   (sLapCnt),
        .err_cnt   (sErrCnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advances the reference model by one edge using the inputs applied.
    task automatic modelUpdate(input logic [3:0] r, input logic e,
                               input logic rs, input logic c);
        int ones;
        int p;
        ones = $countones(r);
        p = 0;
        for (int k = 0; k < W; k++) begin
            if (r[k]) p = k;
        end
        if (c) begin
            mState = 0; mPos = 0; mCode = 0; mLap = 0; mErr = 0;
        end else if (rs) begin
            mState = 0; mCode = 0;
        end else if (e) begin
            if (mState == 0) begin
                if (ones == 1) begin
                    mPos = p; mState = 1;
                end
            end else if (mState == 1) begin
                if (ones != 1) begin
                    mState = 2; mCode = 1;
                    if (mErr < 255) mErr++;
                end else if (p == (mPos + 1) % W) begin
                    if (mPos == W - 1 && mLap < 255) mLap++;
                    mPos = p;
                end else begin
                    mState = 2; mCode = 2;
                    if (mErr < 255) mErr++;
                end
            end
        end
    endtask

    // Drives one cycle of inputs, lets the edge happen, updates the model
    // and leaves time 1 unit after the edge for sampling.
    task automatic applyStimulus(input logic [3:0] r, input logic e,
                                 input logic rs, input logic c);
        ringIn = r; en = e; resync = rs; clr = c;
        @(posedge clk);
        modelUpdate(r, e, rs, c);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        total++;
        if ({idx, idxValid, locked, err, errCode, lapCnt, errCnt} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset got=%h want=0",
                     {idx, idxValid, locked, err, errCode, lapCnt, errCnt});
        end
        total++;
        if ({sLapCnt, sErrCnt, sLocked, sErr} !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset_sat got=%h want=0", {sLapCnt, sErrCnt, sLocked, sErr});
        end
    endtask

    task automatic test_lock_rotate();
        logic [3:0] pat [5];
        logic [1:0] expIdx [5];
        pat    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        expIdx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pat[i], 1'b1, 1'b0, 1'b0);
            total++;
            if (idx !== expIdx[i] || locked !== 1'b1 || idxValid !== 1'b1 || err !== 1'b0) begin
                bad++;
                $display("[TB] FAIL lock_rotate step %0d got idx=%0d lk=%b v=%b e=%b want idx=%0d lk=1 v=1 e=0",
                         i, idx, locked, idxValid, err, expIdx[i]);
            end
        end
        total++;
        if (lapCnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL lap_count got=%0d want=1", lapCnt);
        end
    endtask

    task automatic test_onehot_err();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0);
        total++;
        if (err !== 1'b1 || errCode !== 2'b01 || errCnt !== 8'd1 || idxValid !== 1'b0 ||
            idx !== 2'd1 || locked !== 1'b0) begin
            bad++;
            $display("[TB] FAIL onehot_err got e=%b code=%b cnt=%0d v=%b idx=%0d lk=%b want 1 01 1 0 1 0",
                     err, errCode, errCnt, idxValid, idx, locked);
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        total++;
        if (errCnt !== 8'd1 || err !== 1'b1 || errCode !== 2'b01) begin
            bad++;
            $display("[TB] FAIL err_sticky got cnt=%0d e=%b code=%b want 1 1 01", errCnt, err, errCode);
        end
    endtask

    task automatic test_rotate_err();
        logic [7:0] lapBefore;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        total++;
        if (errCode !== 2'b10 || errCnt !== 8'd1 || err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rotate_err got code=%b cnt=%0d e=%b want 10 1 1", errCode, errCnt, err);
        end
        lapBefore = lapCnt;
        applyStimulus(4'b1000, 1'b1, 1'b1, 1'b0);
        total++;
        if (err !== 1'b0 || errCode !== 2'b00 || locked !== 1'b0 || errCnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL resync got e=%b code=%b lk=%b cnt=%0d want 0 00 0 1", err, errCode, locked, errCnt);
        end
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        total++;
        if (locked !== 1'b1 || idx !== 2'd3 || lapCnt !== lapBefore || lapCnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL relock got lk=%b idx=%0d lap=%0d want 1 3 0", locked, idx, lapCnt);
        end
    endtask

    task automatic test_en_gating();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
        total++;
        if (err !== 1'b0 || idx !== 2'd2 || locked !== 1'b1 || errCnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL en_gate got e=%b idx=%0d lk=%b cnt=%0d want 0 2 1 0", err, idx, locked, errCnt);
        end
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        total++;
        if (idx !== 2'd3 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL en_resume got idx=%0d e=%b want 3 0", idx, err);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        total++;
        if (lapCnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL lock_no_lap got=%0d want=0", lapCnt);
        end
        for (int l = 0; l < 5; l++) begin
            for (int s = 0; s < 4; s++) applyStimulus(seq[s], 1'b1, 1'b0, 1'b0);
        end
        total++;
        if (lapCnt !== 8'd5 || sLapCnt !== 2'd3) begin
            bad++;
            $display("[TB] FAIL lap_sat got lap=%0d sat=%0d want 5 3", lapCnt, sLapCnt);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
            applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
            applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        end
        total++;
        if (errCnt !== 8'd4 || sErrCnt !== 2'd3 || sLapCnt !== 2'd3 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_sat got cnt=%0d sat=%0d slap=%0d e=%b want 4 3 3 0",
                     errCnt, sErrCnt, sLapCnt, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < 4; s++) applyStimulus(seq[s], 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        total++;
        if (idx !== 2'd2 || lapCnt !== 8'd2) begin
            bad++;
            $display("[TB] FAIL pre_reset got idx=%0d lap=%0d want 2 2", idx, lapCnt);
        end
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1);
        total++;
        if ({idx, idxValid, locked, err, errCode, lapCnt, errCnt} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid got=%h want=0",
                     {idx, idxValid, locked, err, errCode, lapCnt, errCnt});
        end
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        total++;
        if (locked !== 1'b1 || idx !== 2'd2 || lapCnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_relock got lk=%b idx=%0d lap=%0d want 1 2 0", locked, idx, lapCnt);
        end
    endtask

    // Random traffic: mostly correct rotations, with junk, skips, enable
    // gaps, resyncs and occasional resets mixed in; every cycle is checked
    // against the reference model on both instances.
    task automatic test_random();
        logic [3:0]  r;
        logic        e;
        logic        rs;
        logic        c;
        logic [22:0] exp;
        logic [3:0]  expSat;
        int          sel;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 75) begin
                if (mState == 1) r = 4'(1 << ((mPos + 1) % W));
                else             r = 4'(1 << $urandom_range(0, W - 1));
            end else if (sel < 88) begin
                r = 4'($urandom_range(0, 15));
            end else begin
                r = 4'(1 << $urandom_range(0, W - 1));
            end
            e  = ($urandom_range(0, 4) != 0);
            rs = ($urandom_range(0, 29) == 0);
            c  = ($urandom_range(0, 79) == 0);
            applyStimulus(r, e, rs, c);
            exp = {2'(mPos), (mState == 1), (mState == 1), (mState == 2), 2'(mCode),
                   8'(mLap), 8'(mErr)};
            total++;
            if ({idx, idxValid, locked, err, errCode, lapCnt, errCnt} !== exp) begin
                bad++;
                $display("[TB] FAIL random cyc %0d got=%h want=%h", n,
                         {idx, idxValid, locked, err, errCode, lapCnt, errCnt}, exp);
            end
            expSat = {(mLap > 3) ? 2'd3 : 2'(mLap), (mErr > 3) ? 2'd3 : 2'(mErr)};
            total++;
            if ({sLapCnt, sErrCnt} !== expSat) begin
                bad++;
                $display("[TB] FAIL random_sat cyc %0d got=%h want=%h", n, {sLapCnt, sErrCnt}, expSat);
            end
        end
    endtask

    // Test sequence.
    initial begin
        clr = 1'b1; en = 1'b0; resync = 1'b0; ringIn = 4'b0000;
        mState = 0; mPos = 0; mCode = 0; mLap = 0; mErr = 0;
        #1;
        test_reset();
        test_lock_rotate();
        test_onehot_err();
        test_rotate_err();
        test_en_gating();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
